// File: rtl/hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scan
// Purpose  : Time-multiplexed 8-digit seven-segment scan controller with a
//            frame-synchronous double buffer and per-slot anti-ghost blanking.
//            Optional leading-zero suppression: HEX_DISPLAY_LEADING_ZERO_BLANK_EN
// Revision : 1.0  initial release
// ============================================================================
module hex_display_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic [3:0]  hex_nibble,
    output logic [7:0]  digitselect,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int                 c_CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK    = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [2:0]         c_LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    logic [c_CNT_W-1:0] r_div_cnt;
    logic [c_CNT_W-1:0] w_div_next;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    state_t             r_state;
    state_t             w_state_next;

    logic [31:0]        r_pend_value;
    logic [7:0]         r_pend_dp;
    logic [7:0]         r_pend_en;
    logic               r_pend_valid;
    logic [31:0]        r_act_value;
    logic [7:0]         r_act_dp;
    logic [7:0]         r_act_en;

    logic               w_slot_end;
    logic               w_frame_end;
    logic               w_lz_blank;
    logic               w_show;
    logic [3:0]         w_nibble;
    logic [7:0]         w_select;
    logic               w_dp_n;

    assign w_slot_end  = (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_LAST_IDX);
    assign w_div_next  = w_slot_end ? '0 : (r_div_cnt + c_CNT_ONE);
    assign w_idx_next  = !w_slot_end ? r_idx :
                         (r_idx == c_LAST_IDX) ? 3'd0 : (r_idx + 3'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_idx     <= 3'd0;
            r_state   <= ST_BLANK;
        end else begin
            r_div_cnt <= w_div_next;
            r_idx     <= w_idx_next;
            r_state   <= w_state_next;
        end
    end

    // State tracks the counter value it will sit beside next cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BLANK: if (w_div_next >= c_BLANK) w_state_next = ST_ON;
            ST_ON:    if (w_div_next <  c_BLANK) w_state_next = ST_BLANK;
            default:  w_state_next = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_value <= 32'h0;
            r_pend_dp    <= 8'h00;
            r_pend_en    <= 8'hFF;
            r_pend_valid <= 1'b0;
            r_act_value  <= 32'h0;
            r_act_dp     <= 8'h00;
            r_act_en     <= 8'hFF;
        end else if (load && w_frame_end) begin
            // Newest data bypasses the pending stage on the boundary itself.
            r_act_value  <= value;
            r_act_dp     <= dp_in;
            r_act_en     <= digit_en;
            r_pend_valid <= 1'b0;
        end else begin
            if (load) begin
                r_pend_value <= value;
                r_pend_dp    <= dp_in;
                r_pend_en    <= digit_en;
                r_pend_valid <= 1'b1;
            end
            if (w_frame_end && r_pend_valid) begin
                r_act_value  <= r_pend_value;
                r_act_dp     <= r_pend_dp;
                r_act_en     <= r_pend_en;
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    logic w_upper_nz;

    // Any non-zero nibble or lit point at or above idx keeps the digit on.
    always_comb begin
        w_upper_nz = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((3'(i) >= r_idx) && ((r_act_value[4*i +: 4] != 4'h0) || r_act_dp[i])) begin
                w_upper_nz = 1'b1;
            end
        end
    end

    assign w_lz_blank = (r_idx != 3'd0) && !w_upper_nz;
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_nibble = r_act_value[{r_idx, 2'b00} +: 4];
    assign w_show   = (r_state == ST_ON) && r_act_en[r_idx] && !w_lz_blank;
    assign w_select = w_show ? ~(8'b1 << r_idx) : 8'hFF;
    assign w_dp_n   = w_show ? ~r_act_dp[r_idx] : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_nibble  <= 4'h0;
            digitselect <= 8'hFF;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hex_nibble  <= w_nibble;
            digitselect <= w_select;
            dp_n        <= w_dp_n;
            frame_start <= w_frame_end;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scan.sv
`default_nettype none
// Directed bench for hex_display_scan: a cycle-level reference model queues
// the expected registered outputs, which are compared one clock later.
module tb_hex_display_scan;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] value = 32'h0;
    logic [7:0]  dp_in = 8'h00;
    logic [7:0]  digit_en = 8'h00;
    logic        load = 1'b0;
    logic [3:0]  hex_nibble;
    logic [7:0]  digitselect;
    logic        dp_n;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] sel;
        logic [3:0] nib;
        logic       dpn;
        logic       fs;
    } exp_t;

    exp_t q[$];

    // Reference model state
    int          m_cyc;
    logic [31:0] m_val, m_pval;
    logic [7:0]  m_dp, m_pdp, m_en, m_pen;
    logic        m_pv;

    hex_display_scan #(
        .NUM_DIGITS  (8),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .hex_nibble (hex_nibble),
        .digitselect(digitselect),
        .dp_n       (dp_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_val  = 32'h0; m_pval = 32'h0;
        m_dp   = 8'h00; m_pdp  = 8'h00;
        m_en   = 8'hFF; m_pen  = 8'hFF;
        m_pv   = 1'b0;
        q.delete();
    endtask

    function automatic logic lz_off(input int idx);
        logic nz;
        nz = 1'b0;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
        for (int i = idx; i < 8; i++) begin
            if (m_val[i*4 +: 4] != 4'h0 || m_dp[i]) nz = 1'b1;
        end
        return (idx > 0) && !nz;
`else
        return nz;
`endif
    endfunction

    // One clock: push what this cycle's state must produce, clock, then compare.
    task automatic step();
        int   dv, ix;
        logic show, bnd;
        exp_t e, g;
        dv   = m_cyc % 8;
        ix   = (m_cyc / 8) % 8;
        bnd  = (dv == 7) && (ix == 7);
        show = (dv >= 2) && m_en[ix] && !lz_off(ix);
        e.sel = show ? ~(8'h01 << ix) : 8'hFF;
        e.nib = m_val[ix*4 +: 4];
        e.dpn = show ? ~m_dp[ix] : 1'b1;
        e.fs  = bnd;
        q.push_back(e);
        if (load && bnd) begin
            m_val = value; m_dp = dp_in; m_en = digit_en; m_pv = 1'b0;
        end else begin
            if (load) begin
                m_pval = value; m_pdp = dp_in; m_pen = digit_en; m_pv = 1'b1;
            end
            if (bnd && m_pv) begin
                m_val = m_pval; m_dp = m_pdp; m_en = m_pen; m_pv = 1'b0;
            end
        end
        m_cyc++;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 8'd0, 8'd1);
        end else begin
            g = q.pop_front();
            chk("digitselect", digitselect, g.sel);
            chk("hex_nibble", {4'h0, hex_nibble}, {4'h0, g.nib});
            chk("dp_n", {7'h0, dp_n}, {7'h0, g.dpn});
            chk("frame_start", {7'h0, frame_start}, {7'h0, g.fs});
            chk("one_hot_low", 8'($countones(~digitselect) <= 1), 8'd1);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < 64 && (m_cyc % 64) != pos; i++) step();
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
        value = v; dp_in = dp; digit_en = en; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"}, digitselect, 8'hFF);
        chk({tag, "_dpn"}, {7'h0, dp_n}, 8'h01);
        chk({tag, "_nib"}, {4'h0, hex_nibble}, 8'h00);
        chk({tag, "_fs"}, {7'h0, frame_start}, 8'h00);
    endtask

    initial begin
        model_reset();
        // Reset held for five cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("reset");
        end
        reset_n = 1'b1;

        // First frame from reset: value 0, all enabled, first pulse after 64 cycles
        run(66);

        // Basic scan
        run_to(10);
        do_load(32'h1234ABCD, 8'h00, 8'hFF);
        run_to(0);
        run(64);

        // Tear-free update loaded while digit 3 is on
        run_to(3*8 + 4);
        do_load(32'h11111111, 8'h00, 8'hFF);
        run_to(0);
        run(64);

        // Load exactly on the frame boundary with enable mask and decimal point
        run_to(63);
        do_load(32'h000000FF, 8'h02, 8'h0F);
        run(128);

        // Asynchronous reset during digit 5 ON phase
        run_to(5*8 + 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        reset_n = 1'b1;
        run(70);

        // Leading-zero case and all-zero value
        do_load(32'h00000042, 8'h00, 8'hFF);
        run_to(0);
        run(64);
        do_load(32'h00000000, 8'h00, 8'hFF);
        run_to(0);
        run(64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
